// File: rtl/record_serializer_pkg.sv
// record_serializer_pkg: shared record width default and FSM state encodings
// for the record serializer (legacy 2-bit encodings kept for compatibility).
package record_serializer_pkg;

  localparam int unsigned REC_W_DEFAULT = 48;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_CKSUM = 2'd3;

endpackage

// File: rtl/record_serializer.sv
// record_serializer: drains REC_W-bit timetag records from a non-show-ahead
// FIFO and presents them LSB byte first to the FX2 host link with a
// data_rdy/data_ack handshake. One record in flight at a time.
// Optional feature: define RECORD_SERIALIZER_CHECKSUM_EN to append one XOR
// checksum byte per record (frame = REC_BYTES+1 bytes).
module record_serializer
  import record_serializer_pkg::*;
#(
  parameter int unsigned REC_W = REC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_rdy,
  input  logic [REC_W-1:0] sample,
  output logic             sample_req,
  output logic             data_rdy,
  output logic [7:0]       data,
  input  logic             data_ack,
  output logic             rec_sent
);

  localparam int unsigned REC_BYTES = REC_W / 8;
  localparam int unsigned IDX_W     = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

  logic [1:0]       state_q,    state_d;
  logic [REC_W-1:0] shreg_q,    shreg_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [7:0]       data_q,     data_d;
  logic             data_rdy_q, data_rdy_d;
  logic             rec_sent_q, rec_sent_d;
  logic             req_c;
  logic             ack_c;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  logic [7:0]       cks_q,      cks_d;
`endif

  // Next-state logic: FSM, shift register, byte index and registered outputs.
  // data_q is preloaded with the byte that shreg will hold next, so the
  // presented byte always equals shreg[7:0] while in SEND.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    data_d     = data_q;
    data_rdy_d = data_rdy_q;
    rec_sent_d = 1'b0;
    req_c      = 1'b0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    cks_d      = cks_q;
`endif
    ack_c      = data_rdy_q & data_ack;

    case (state_q)
      ST_IDLE: begin
        if (sample_rdy) begin
          req_c   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        shreg_d    = sample;
        idx_d      = '0;
        data_d     = sample[7:0];
        data_rdy_d = 1'b1;
        state_d    = ST_SEND;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
        cks_d      = '0;
`endif
      end
      ST_SEND: begin
        if (ack_c) begin
          shreg_d = shreg_q >> 8;
          idx_d   = idx_q + 1'b1;
          data_d  = shreg_d[7:0];
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
          cks_d   = cks_q ^ shreg_q[7:0];
`endif
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            data_d  = cks_q ^ shreg_q[7:0];
            state_d = ST_CKSUM;
`else
            data_d     = data_q;
            data_rdy_d = 1'b0;
            rec_sent_d = 1'b1;
            state_d    = ST_IDLE;
`endif
          end
        end
      end
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
      ST_CKSUM: begin
        if (ack_c) begin
          data_rdy_d = 1'b0;
          rec_sent_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
`endif
      default: begin
        data_rdy_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      data_rdy_q <= 1'b0;
      rec_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      data_rdy_q <= data_rdy_d;
      rec_sent_q <= rec_sent_d;
    end
  end

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  // Running XOR of the record bytes acked so far.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end
`endif

  // The read strobe is held off while reset is asserted so the FIFO is never
  // popped by a serializer that cannot capture the word.
  assign sample_req = req_c & reset_n;
  assign data_rdy   = data_rdy_q;
  assign data       = data_q;
  assign rec_sent   = rec_sent_q;

endmodule

// File: tb/tb_record_serializer.sv
// tb_record_serializer: table-driven and randomized checks of record_serializer
// against a queue-based model of the FIFO and of the expected byte stream.
module tb_record_serializer;

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
  localparam int FRAME = 7;
`else
  localparam int FRAME = 6;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_rdy;
  logic [47:0] sample;
  logic        sample_req;
  logic        data_rdy;
  logic [7:0]  data;
  logic        data_ack;
  logic        rec_sent;

  record_serializer #(.REC_W(48)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_rdy (sample_rdy),
    .sample     (sample),
    .sample_req (sample_req),
    .data_rdy   (data_rdy),
    .data       (data),
    .data_ack   (data_ack),
    .rec_sent   (rec_sent)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [47:0] fifo[$];
  logic [7:0]  exp_q[$];
  bit          exp_last[$];

  int   cyc = 0;
  bit   rdy_en = 1'b1;
  int   ack_mode = 0;        // 0 none, 1 always, 2 random, 3 delayed after rdy
  int   ack_delay = 1;
  int   stall_byte = -1;
  int   stall_len = 0;
  int   rdy_cnt = 0;
  int   byte_in_frame = 0;
  logic [7:0] got[8];
  bit   rec_pending = 1'b0;
  int   req_cnt = 0;
  int   rec_cnt = 0;
  int   req_cycle = -100;
  int   last_end_cycle = -100;
  bit   gap_check = 1'b0;
  int   gap_from = 0;
  bit   prev_rdy = 1'b0;
  bit   prev_ack = 1'b0;
  logic [7:0] prev_data = '0;

  typedef struct {
    logic [47:0] rec;
    int          dly;
    logic [7:0]  b0;
    logic [7:0]  b5;
    logic [7:0]  x;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a record contributes its bytes LSB first, then optionally their XOR.
  task automatic push_rec(input logic [47:0] r);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    fifo.push_back(r);
    for (int i = 0; i < 6; i++) begin
      b = r[8*i +: 8];
      exp_q.push_back(b);
      exp_last.push_back(FRAME == 6 && i == 5);
      x ^= b;
    end
    if (FRAME == 7) begin
      exp_q.push_back(x);
      exp_last.push_back(1'b1);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance.
  task automatic step();
    bit pop_now;
    int dly;
    logic [7:0] e;
    bit lst;
    pop_now = 1'b0;
    sample_rdy = rdy_en && (fifo.size() > 0);
    case (ack_mode)
      1: data_ack = 1'b1;
      2: data_ack = 1'($urandom_range(0, 1));
      3: begin
        dly = (byte_in_frame == stall_byte) ? stall_len : ack_delay;
        data_ack = data_rdy && (rdy_cnt >= dly);
      end
      default: data_ack = 1'b0;
    endcase
    #1;
    chk("rec_sent", rec_sent, rec_pending);
    if (rec_sent) rec_cnt++;
    rec_pending = 1'b0;
    if (sample_req) begin
      chk("req_needs_rdy", sample_rdy, 1);
      req_cnt++;
      req_cycle = cyc;
      pop_now = 1'b1;
    end
    if (data_rdy && !prev_rdy) begin
      chk("first_byte_latency", cyc - req_cycle, 2);
      if (gap_check && last_end_cycle >= gap_from)
        chk("record_gap", cyc - last_end_cycle, 3);
    end
    if (prev_rdy && !prev_ack) begin
      chk("rdy_held", data_rdy, 1);
      if (data_rdy) chk("data_held", data, prev_data);
    end
    if (data_rdy && exp_q.size() == 0) chk("unexpected_rdy", data_rdy, 0);
    if (data_rdy && data_ack && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      lst = exp_last.pop_front();
      chk("byte", data, e);
      got[byte_in_frame] = data;
      byte_in_frame++;
      if (lst) begin
        rec_pending = 1'b1;
        byte_in_frame = 0;
        last_end_cycle = cyc;
      end
      rdy_cnt = 0;
    end else if (data_rdy) begin
      rdy_cnt++;
    end else begin
      rdy_cnt = 0;
    end
    prev_rdy = data_rdy;
    prev_ack = data_ack;
    prev_data = data;
    @(posedge clk);
    #1;
    if (pop_now && fifo.size() > 0) sample = fifo.pop_front();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || rec_pending) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int r0, c0, n;
    reset_n = 1'b0;
    sample_rdy = 1'b0;
    sample = '0;
    data_ack = 1'b0;

    tbl[0] = '{48'h0605_0403_0201, 1, 8'h01, 8'h06, 8'h07};
    tbl[1] = '{48'hFFEE_DDCC_BBAA, 0, 8'hAA, 8'hFF, 8'h11};
    tbl[2] = '{48'h8000_0000_0001, 3, 8'h01, 8'h80, 8'h81};
    tbl[3] = '{48'h0000_0000_0000, 2, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{48'h1234_5678_9ABC, 1, 8'hBC, 8'h12, 8'h2E};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_sample_req", sample_req, 0);
    chk("reset_data_rdy", data_rdy, 0);
    chk("reset_data", data, 0);
    chk("reset_rec_sent", rec_sent, 0);
    reset_n = 1'b1;
    repeat (3) step();

    // Table-driven single records with varying host delay
    ack_mode = 3;
    for (int i = 0; i < 5; i++) begin
      r0 = req_cnt;
      c0 = rec_cnt;
      ack_delay = tbl[i].dly;
      push_rec(tbl[i].rec);
      drain(200);
      chk("tbl_first_byte", got[0], tbl[i].b0);
      chk("tbl_last_rec_byte", got[5], tbl[i].b5);
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
      chk("tbl_checksum", got[6], tbl[i].x);
`endif
      chk("tbl_req_count", req_cnt - r0, 1);
      chk("tbl_rec_sent_count", rec_cnt - c0, 1);
      repeat (2) step();
    end

    // Ack tied high, three records back to back
    ack_mode = 1;
    r0 = req_cnt;
    c0 = rec_cnt;
    gap_check = 1'b1;
    gap_from = cyc;
    push_rec(48'hA5A4_A3A2_A1A0);
    push_rec(48'hB5B4_B3B2_B1B0);
    push_rec(48'hC5C4_C3C2_C1C0);
    drain(200);
    gap_check = 1'b0;
    chk("b2b_req_count", req_cnt - r0, 3);
    chk("b2b_rec_sent_count", rec_cnt - c0, 3);

    // Spurious acks while idle, then a 20-cycle stall on the third byte
    repeat (5) step();
    ack_mode = 3;
    ack_delay = 1;
    stall_byte = 2;
    stall_len = 20;
    r0 = req_cnt;
    push_rec(48'h0605_0403_0201);
    drain(200);
    stall_byte = -1;
    chk("stall_third_byte", got[2], 8'h03);
    chk("stall_req_count", req_cnt - r0, 1);

    // Records held back by sample_rdy low for 100 cycles
    rdy_en = 1'b0;
    ack_mode = 1;
    r0 = req_cnt;
    push_rec(48'h1111_2222_3333);
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 25 == 0) chk("blocked_data_rdy", data_rdy, 0);
    end
    chk("blocked_req_count", req_cnt - r0, 0);
    rdy_en = 1'b1;
    drain(200);
    chk("unblocked_req_count", req_cnt - r0, 1);

    // Reset in the middle of a record
    ack_mode = 3;
    ack_delay = 1;
    r0 = req_cnt;
    push_rec(48'hDEAD_BEEF_CAFE);
    n = 0;
    while (byte_in_frame < 2 && n < 100) begin
      step();
      n++;
    end
    chk("reset_mid_reached", byte_in_frame, 2);
    reset_n = 1'b0;
    #1;
    chk("midreset_sample_req", sample_req, 0);
    chk("midreset_data_rdy", data_rdy, 0);
    chk("midreset_data", data, 0);
    chk("midreset_rec_sent", rec_sent, 0);
    exp_q.delete();
    exp_last.delete();
    byte_in_frame = 0;
    rec_pending = 1'b0;
    prev_rdy = 1'b0;
    prev_ack = 1'b0;
    rdy_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) step();
    chk("post_reset_req_count", req_cnt - r0, 1);

    // Randomized records, host acks and FIFO availability
    ack_mode = 2;
    r0 = req_cnt;
    c0 = rec_cnt;
    for (int i = 0; i < 25; i++) push_rec({$urandom(), 16'($urandom())});
    n = 0;
    while ((exp_q.size() > 0 || rec_pending) && n < 3000) begin
      rdy_en = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    rdy_en = 1'b1;
    drain(200);
    chk("rand_req_count", req_cnt - r0, 25);
    chk("rand_rec_sent_count", rec_cnt - c0, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
